dcmac_link_sequencer: RTL and testbench
=======================================

Name: dcmac_link_sequencer

Overview:
Parameterised GT reset and link bring-up sequencer for the DCMAC datapath. It supports N ports of L lanes each. It replaces static reset wiring with a global reset-all sequence that is gated on GT power-good. Each port runs its own bring-up FSM with reset-done debouncing, timeout-driven RX datapath reset retries and saturating retry counters. Its per-port axis resetn and status outputs go to user logic and the AXI register block.

Parameters:
NUM_PORTS, 2, number of MAC ports (1..6)
LANES_PER_PORT, 4, GT lanes aggregated per port
SYNC_STAGES, 3, flip-flop stages on async GT inputs (>=2)
RST_PULSE, 64, cycles for which each GT reset output is held high
TIMEOUT_CYCLES, 250000, maximum P_WAIT dwell before a retry
STABLE_CYCLES, 1024, cycles that "ready" must stay continuously high before a port is declared up
RETRY_W, 8, width of each per-port retry counter

Ports:
s_axi_clk  in  1  sole clock
reset  in  1  synchronous, active-high
gtpowergood  in  1  async; AND of all quads' power-good
gt_rx_reset_done_in  in  NUM_PORTS*LANES_PER_PORT  async; lane i of port p is at bit p*L+i
gt_tx_reset_done_in  in  NUM_PORTS*LANES_PER_PORT  async; same packing as rx
user_reset_all  in  1  one-cycle request to restart everything
user_reset_rx_datapath  in  NUM_PORTS  one-cycle per-port RX datapath reset request
gt_reset_all_out  out  1  to DCMAC gt_reset_all_in
gt_reset_rx_datapath_out  out  NUM_PORTS  to DCMAC gt_reset_rx_datapath_in_p
axis_resetn  out  NUM_PORTS  per-port active-low stream reset, s_axi_clk domain
port_up  out  NUM_PORTS  high while the port FSM is in P_UP
port_state  out  3*NUM_PORTS  encoded state of each port FSM
retry_count  out  RETRY_W*NUM_PORTS  saturating timeout-retry count per port

Behaviour:
- Reset: clock is s_axi_clk; reset is synchronous, active-high.
- Values during and after reset:
  - gt_reset_all_out=0, gt_reset_rx_datapath_out=0, axis_resetn=0, port_up=0.
  - All port_state=P_IDLE(0); all retry_count=0.
  - Global FSM in G_WAIT_PWR; synchronizer flops cleared to 0.
- Synchronizers: all async inputs pass through SYNC_STAGES flops. pg_s is synced gtpowergood.
- ready[p] = AND over the port's lanes of synced rx_done & tx_done.
- Global FSM (states G_WAIT_PWR, G_RESET_ALL, G_RUN):
  - G_WAIT_PWR: move to G_RESET_ALL on pg_s=1.
  - G_RESET_ALL: gt_reset_all_out=1 for exactly RST_PULSE cycles, then G_RUN.
  - G_RUN: move to G_RESET_ALL on user_reset_all.
  - Any state: pg_s=0 forces G_WAIT_PWR next cycle, with priority over user_reset_all.
  - user_reset_all while in G_RESET_ALL restarts the pulse counter.
  - Outside G_RUN, every port FSM is forced to P_IDLE; retry_count is preserved.
- Port FSM, one per port. Encodings: P_IDLE=0, P_RST=1, P_WAIT=2, P_STABLE=3, P_UP=4.
  - P_IDLE: when global is G_RUN, go to P_WAIT.
  - P_RST: gt_reset_rx_datapath_out[p]=1 for RST_PULSE cycles, then P_WAIT.
  - P_WAIT: shares one counter with P_STABLE, cleared on entry.
    - ready[p]=1 -> P_STABLE.
    - Counter reaching TIMEOUT_CYCLES-1 -> P_RST, and retry_count[p] increments (saturates at all-ones, no wrap).
  - P_STABLE: ready[p]=0 -> P_WAIT with no retry increment. STABLE_CYCLES consecutive ready cycles -> P_UP.
  - P_UP: axis_resetn[p]=1 and port_up[p]=1, both registered and asserted in the first P_UP cycle. ready[p]=0 -> P_WAIT.
  - user_reset_rx_datapath[p] in P_WAIT, P_STABLE or P_UP -> P_RST, no retry increment.
    - In P_RST it restarts the pulse.
    - In P_IDLE it is ignored.
  - A timeout and a user request in the same cycle: user request wins and the counter does not increment.
- axis_resetn[p]=0 in every state other than P_UP.
- Ports are fully independent; one port retrying never disturbs another.
- Output registering and latency:
  - All outputs are registered.
  - gtpowergood rise to gt_reset_all_out rise = SYNC_STAGES+1 cycles.
  - ready rise in P_WAIT to P_UP = SYNC_STAGES + STABLE_CYCLES + 1 cycles.

Test Plan:
Params for all scenarios: NUM_PORTS=2, L=4, SYNC_STAGES=2, RST_PULSE=4, TIMEOUT_CYCLES=20, STABLE_CYCLES=8.
1. Bring-up: release reset, raise gtpowergood. All done lanes go high after G_RUN -> gt_reset_all_out high exactly 4 cycles starting 3 cycles after the rise; both ports reach P_UP; axis_resetn=2'b11.
2. Timeout retry: port1 rx lane 2 held low -> port1 cycles P_WAIT (20 cycles) then P_RST (4-cycle pulse) repeatedly, retry_count[1] increments 1,2,3. Port0 reaches P_UP with retry_count 0.
3. Saturation: RETRY_W=2, lane held low for 5 timeouts -> retry_count sticks at 3.
4. Debounce glitch: ready[0] drops for 1 cycle mid P_STABLE -> returns to P_WAIT, and P_UP is reached 8 stable cycles after recovery. Drop in P_UP -> axis_resetn[0]=0 on the next cycle and state=2.
5. User requests: user_reset_rx_datapath=2'b01 in P_UP -> gt_reset_rx_datapath_out[0] 4-cycle pulse, retry unchanged. Same request coinciding with a timeout -> no increment.
6. Power loss and global reset: gtpowergood drops in G_RUN -> all ports P_IDLE, axis_resetn=0, counters kept. user_reset_all in G_RESET_ALL restarts the 4-cycle pulse. Assert reset mid-sequence -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/dcmac_link_sequencer.sv
// GT reset and link bring-up sequencer for the DCMAC datapath: a global reset-all
// FSM gated on power-good, plus one debounce/retry bring-up FSM per MAC port.
module dcmac_link_sequencer #(
  parameter int NUM_PORTS      = 2,
  parameter int LANES_PER_PORT = 4,
  parameter int SYNC_STAGES    = 3,
  parameter int RST_PULSE      = 64,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRY_W        = 8
) (
  input  logic                                s_axi_clk,
  input  logic                                reset,
  input  logic                                gtpowergood,
  input  logic [NUM_PORTS*LANES_PER_PORT-1:0] gt_rx_reset_done_in,
  input  logic [NUM_PORTS*LANES_PER_PORT-1:0] gt_tx_reset_done_in,
  input  logic                                user_reset_all,
  input  logic [NUM_PORTS-1:0]                user_reset_rx_datapath,
  output logic                                gt_reset_all_out,
  output logic [NUM_PORTS-1:0]                gt_reset_rx_datapath_out,
  output logic [NUM_PORTS-1:0]                axis_resetn,
  output logic [NUM_PORTS-1:0]                port_up,
  output logic [3*NUM_PORTS-1:0]              port_state,
  output logic [RETRY_W*NUM_PORTS-1:0]        retry_count
);

  localparam int NL = NUM_PORTS * LANES_PER_PORT;
  localparam int TS_MAX = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int PCNT_MAX = (TS_MAX > RST_PULSE) ? TS_MAX : RST_PULSE;
  localparam int PCNT_W = $clog2(PCNT_MAX + 1);
  localparam int GCNT_W = $clog2(RST_PULSE + 1);

  localparam logic [GCNT_W-1:0] G_LAST   = GCNT_W'(RST_PULSE - 1);
  localparam logic [PCNT_W-1:0] RST_LAST = PCNT_W'(RST_PULSE - 1);
  localparam logic [PCNT_W-1:0] TMO_LAST = PCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PCNT_W-1:0] STB_LAST = PCNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    G_WAIT_PWR  = 2'd0,
    G_RESET_ALL = 2'd1,
    G_RUN       = 2'd2
  } gstate_t;

  typedef enum logic [2:0] {
    P_IDLE   = 3'd0,
    P_RST    = 3'd1,
    P_WAIT   = 3'd2,
    P_STABLE = 3'd3,
    P_UP     = 3'd4
  } pstate_t;

  logic [SYNC_STAGES-1:0]         pg_sync_q, pg_sync_d;
  logic [SYNC_STAGES-1:0][NL-1:0] rx_sync_q, rx_sync_d;
  logic [SYNC_STAGES-1:0][NL-1:0] tx_sync_q, tx_sync_d;
  logic                           pg_s;
  logic [NL-1:0]                  rx_s, tx_s;
  logic [NUM_PORTS-1:0]           ready;

  gstate_t                        gstate_q, gstate_d;
  logic [GCNT_W-1:0]              gcnt_q, gcnt_d;
  logic                           gt_reset_all_q, gt_reset_all_d;
  logic                           run;

  pstate_t                        pstate_q [NUM_PORTS];
  pstate_t                        pstate_d [NUM_PORTS];
  logic [PCNT_W-1:0]              pcnt_q [NUM_PORTS];
  logic [PCNT_W-1:0]              pcnt_d [NUM_PORTS];
  logic [RETRY_W-1:0]             retry_q [NUM_PORTS];
  logic [RETRY_W-1:0]             retry_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]           rstdp_q, rstdp_d;
  logic [NUM_PORTS-1:0]           up_q, up_d;

  // Synchronizer stage: shift each async input in at index 0
  always_comb begin
    pg_sync_d = {pg_sync_q[SYNC_STAGES-2:0], gtpowergood};
    rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], gt_rx_reset_done_in};
    tx_sync_d = {tx_sync_q[SYNC_STAGES-2:0], gt_tx_reset_done_in};
    pg_s      = pg_sync_q[SYNC_STAGES-1];
    rx_s      = rx_sync_q[SYNC_STAGES-1];
    tx_s      = tx_sync_q[SYNC_STAGES-1];
    for (int p = 0; p < NUM_PORTS; p++) begin
      ready[p] = &(rx_s[p*LANES_PER_PORT +: LANES_PER_PORT] &
                   tx_s[p*LANES_PER_PORT +: LANES_PER_PORT]);
    end
  end

  // Global reset-all FSM; loss of power-good overrides everything
  always_comb begin
    gstate_d = gstate_q;
    gcnt_d   = gcnt_q;
    case (gstate_q)
      G_WAIT_PWR: begin
        if (pg_s) begin
          gstate_d = G_RESET_ALL;
          gcnt_d   = '0;
        end
      end
      G_RESET_ALL: begin
        if (user_reset_all) begin
          gcnt_d = '0;
        end else if (gcnt_q == G_LAST) begin
          gstate_d = G_RUN;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      G_RUN: begin
        if (user_reset_all) begin
          gstate_d = G_RESET_ALL;
          gcnt_d   = '0;
        end
      end
      default: gstate_d = G_WAIT_PWR;
    endcase
    if (!pg_s) begin
      gstate_d = G_WAIT_PWR;
      gcnt_d   = '0;
    end
    gt_reset_all_d = (gstate_d == G_RESET_ALL);
    run            = (gstate_q == G_RUN);
  end

  // Per-port bring-up FSMs; one counter per port serves pulse, timeout and debounce
  always_comb begin
    pstate_d = pstate_q;
    pcnt_d   = pcnt_q;
    retry_d  = retry_q;
    rstdp_d  = '0;
    up_d     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      case (pstate_q[p])
        P_IDLE: begin
          if (run) begin
            pstate_d[p] = P_WAIT;
            pcnt_d[p]   = '0;
          end
        end
        P_RST: begin
          if (user_reset_rx_datapath[p]) begin
            pcnt_d[p] = '0;
          end else if (pcnt_q[p] == RST_LAST) begin
            pstate_d[p] = P_WAIT;
            pcnt_d[p]   = '0;
          end else begin
            pcnt_d[p] = pcnt_q[p] + 1'b1;
          end
        end
        P_WAIT: begin
          if (user_reset_rx_datapath[p]) begin
            pstate_d[p] = P_RST;
            pcnt_d[p]   = '0;
          end else if (ready[p]) begin
            pstate_d[p] = P_STABLE;
            pcnt_d[p]   = '0;
          end else if (pcnt_q[p] == TMO_LAST) begin
            pstate_d[p] = P_RST;
            pcnt_d[p]   = '0;
            if (retry_q[p] != '1) retry_d[p] = retry_q[p] + 1'b1;
          end else begin
            pcnt_d[p] = pcnt_q[p] + 1'b1;
          end
        end
        P_STABLE: begin
          if (user_reset_rx_datapath[p]) begin
            pstate_d[p] = P_RST;
            pcnt_d[p]   = '0;
          end else if (!ready[p]) begin
            pstate_d[p] = P_WAIT;
            pcnt_d[p]   = '0;
          end else if (pcnt_q[p] == STB_LAST) begin
            pstate_d[p] = P_UP;
          end else begin
            pcnt_d[p] = pcnt_q[p] + 1'b1;
          end
        end
        P_UP: begin
          if (user_reset_rx_datapath[p]) begin
            pstate_d[p] = P_RST;
            pcnt_d[p]   = '0;
          end else if (!ready[p]) begin
            pstate_d[p] = P_WAIT;
            pcnt_d[p]   = '0;
          end
        end
        default: pstate_d[p] = P_IDLE;
      endcase
      if (!run) begin
        pstate_d[p] = P_IDLE;
        pcnt_d[p]   = '0;
      end
      rstdp_d[p] = (pstate_d[p] == P_RST);
      up_d[p]    = (pstate_d[p] == P_UP);
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (reset) begin
      pg_sync_q      <= '0;
      rx_sync_q      <= '0;
      tx_sync_q      <= '0;
      gstate_q       <= G_WAIT_PWR;
      gcnt_q         <= '0;
      gt_reset_all_q <= 1'b0;
      rstdp_q        <= '0;
      up_q           <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        pstate_q[p] <= P_IDLE;
        pcnt_q[p]   <= '0;
        retry_q[p]  <= '0;
      end
    end else begin
      pg_sync_q      <= pg_sync_d;
      rx_sync_q      <= rx_sync_d;
      tx_sync_q      <= tx_sync_d;
      gstate_q       <= gstate_d;
      gcnt_q         <= gcnt_d;
      gt_reset_all_q <= gt_reset_all_d;
      rstdp_q        <= rstdp_d;
      up_q           <= up_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        pstate_q[p] <= pstate_d[p];
        pcnt_q[p]   <= pcnt_d[p];
        retry_q[p]  <= retry_d[p];
      end
    end
  end

  always_comb begin
    gt_reset_all_out         = gt_reset_all_q;
    gt_reset_rx_datapath_out = rstdp_q;
    axis_resetn              = up_q;
    port_up                  = up_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_state[3*p +: 3]            = pstate_q[p];
      retry_count[RETRY_W*p +: RETRY_W] = retry_q[p];
    end
  end

endmodule

// File: tb/tb_dcmac_link_sequencer.sv
// Directed bench for dcmac_link_sequencer: bring-up, timeout retries, saturation,
// debounce, user requests, power loss and reset.
module tb_dcmac_link_sequencer;

  localparam int NP = 2;
  localparam int L  = 4;
  localparam int RW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             gtpowergood;
  logic [NP*L-1:0]  rx_done;
  logic [NP*L-1:0]  tx_done;
  logic             user_reset_all;
  logic [NP-1:0]    user_rx;
  logic             gt_reset_all_out;
  logic [NP-1:0]    gt_reset_rx_datapath_out;
  logic [NP-1:0]    axis_resetn;
  logic [NP-1:0]    port_up;
  logic [3*NP-1:0]  port_state;
  logic [RW*NP-1:0] retry_count;

  int total = 0;
  int fails = 0;

  dcmac_link_sequencer #(
    .NUM_PORTS(NP), .LANES_PER_PORT(L), .SYNC_STAGES(2), .RST_PULSE(4),
    .TIMEOUT_CYCLES(20), .STABLE_CYCLES(8), .RETRY_W(RW)
  ) dut (
    .s_axi_clk(clk),
    .reset(reset),
    .gtpowergood(gtpowergood),
    .gt_rx_reset_done_in(rx_done),
    .gt_tx_reset_done_in(tx_done),
    .user_reset_all(user_reset_all),
    .user_reset_rx_datapath(user_rx),
    .gt_reset_all_out(gt_reset_all_out),
    .gt_reset_rx_datapath_out(gt_reset_rx_datapath_out),
    .axis_resetn(axis_resetn),
    .port_up(port_up),
    .port_state(port_state),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // port_state packing {p1,p0}: value = p1*8 + p0; retry {p1,p0}: value = p1*4 + p0
  initial begin
    reset = 1'b1; gtpowergood = 1'b0; rx_done = '0; tx_done = '0;
    user_reset_all = 1'b0; user_rx = '0;
    tick(3);
    check("rst_gt_all", 32'(gt_reset_all_out), 0);
    check("rst_gt_rxdp", 32'(gt_reset_rx_datapath_out), 0);
    check("rst_axis", 32'(axis_resetn), 0);
    check("rst_up", 32'(port_up), 0);
    check("rst_state", 32'(port_state), 0);
    check("rst_retry", 32'(retry_count), 0);
    reset = 1'b0;
    tick(1);

    // Bring-up
    gtpowergood = 1'b1;
    tick(2);  check("pg_lat_lo", 32'(gt_reset_all_out), 0);
    tick(1);  check("pg_lat_hi", 32'(gt_reset_all_out), 1);
    tick(3);  check("rstall_last", 32'(gt_reset_all_out), 1);
    tick(1);  check("rstall_end", 32'(gt_reset_all_out), 0);
    check("idle_before_run", 32'(port_state), 0);
    tick(1);  check("wait_entry", 32'(port_state), 18);
    rx_done = 8'hFF; tx_done = 8'hFF;
    tick(10); check("stable_both", 32'(port_state), 27);
    check("axis_stable", 32'(axis_resetn), 0);
    tick(1);  check("up_both", 32'(port_state), 36);
    check("axis_up", 32'(axis_resetn), 3);
    check("port_up_both", 32'(port_up), 3);

    // Timeout retries on port1 (rx lane 2 low), first timeout coincides with user request
    rx_done = 8'hBF;
    tick(2);  check("p1_up_hold", 32'(port_state), 36);
    tick(1);  check("p1_drop", 32'(port_state), 20);
    check("p1_axis_drop", 32'(axis_resetn), 1);
    check("p1_portup_drop", 32'(port_up), 1);
    tick(19); check("p1_wait_end", 32'(port_state), 20);
    user_rx = 2'b10;
    tick(1);  user_rx = 2'b00;
    check("coinc_state", 32'(port_state), 12);
    check("coinc_retry", 32'(retry_count), 0);
    check("coinc_rxdp", 32'(gt_reset_rx_datapath_out), 2);
    tick(3);  check("p1_rst_last", 32'(gt_reset_rx_datapath_out), 2);
    tick(1);  check("p1_rst_end", 32'(gt_reset_rx_datapath_out), 0);
    check("p1_rewait", 32'(port_state), 20);
    tick(19); check("p1_pre_tmo", 32'(retry_count), 0);
    check("p1_pre_tmo_st", 32'(port_state), 20);
    tick(1);  check("retry1", 32'(retry_count), 4);
    check("retry1_st", 32'(port_state), 12);
    tick(4);  check("retry1_wait", 32'(port_state), 20);
    tick(20); check("retry2", 32'(retry_count), 8);
    tick(24); check("retry3", 32'(retry_count), 12);
    tick(24); check("retry_sat4", 32'(retry_count), 12);
    check("retry_sat4_st", 32'(port_state), 12);
    tick(24); check("retry_sat5", 32'(retry_count), 12);
    check("p0_unaffected", 32'(port_state[2:0]), 4);
    rx_done = 8'hFF;
    tick(13); check("p1_recover", 32'(port_state), 36);
    check("p1_recover_axis", 32'(axis_resetn), 3);

    // Debounce: drop in P_UP, then a one-cycle glitch in P_STABLE
    rx_done = 8'hFE;
    tick(2);  check("p0_up_hold", 32'(port_state), 36);
    tick(1);  check("p0_drop", 32'(port_state), 34);
    check("p0_axis_drop", 32'(axis_resetn), 2);
    rx_done = 8'hFF;
    tick(3);  check("p0_stable", 32'(port_state), 35);
    tick(2);  rx_done = 8'hFE;
    tick(1);  rx_done = 8'hFF;
    tick(1);  check("glitch_pre", 32'(port_state), 35);
    tick(1);  check("glitch_wait", 32'(port_state), 34);
    tick(1);  check("glitch_restable", 32'(port_state), 35);
    tick(7);  check("glitch_not_up", 32'(port_state), 35);
    tick(1);  check("glitch_up", 32'(port_state), 36);
    check("glitch_axis", 32'(axis_resetn), 3);

    // User RX datapath reset on port0 in P_UP
    user_rx = 2'b01;
    tick(1);  user_rx = 2'b00;
    check("usr_rst_st", 32'(port_state), 33);
    check("usr_rxdp", 32'(gt_reset_rx_datapath_out), 1);
    check("usr_axis", 32'(axis_resetn), 2);
    tick(3);  check("usr_rxdp_last", 32'(gt_reset_rx_datapath_out), 1);
    tick(1);  check("usr_rxdp_end", 32'(gt_reset_rx_datapath_out), 0);
    tick(9);  check("usr_reup", 32'(port_state), 36);
    check("usr_retry", 32'(retry_count), 12);

    // Power loss, restart with user_reset_all inside the pulse, then hard reset
    gtpowergood = 1'b0;
    tick(2);  check("pl_gt_all", 32'(gt_reset_all_out), 0);
    tick(2);  check("pl_idle", 32'(port_state), 0);
    check("pl_axis", 32'(axis_resetn), 0);
    check("pl_up", 32'(port_up), 0);
    check("pl_retry_kept", 32'(retry_count), 12);
    gtpowergood = 1'b1;
    tick(2);  check("pr_lo", 32'(gt_reset_all_out), 0);
    tick(1);  check("pr_hi", 32'(gt_reset_all_out), 1);
    tick(1);  user_reset_all = 1'b1;
    tick(1);  user_reset_all = 1'b0;
    check("ura_hi", 32'(gt_reset_all_out), 1);
    tick(3);  check("ura_extended", 32'(gt_reset_all_out), 1);
    check("ura_idle", 32'(port_state), 0);
    tick(1);  check("ura_end", 32'(gt_reset_all_out), 0);
    tick(1);  check("rerun_wait", 32'(port_state), 18);
    reset = 1'b1;
    tick(1);
    check("hr_state", 32'(port_state), 0);
    check("hr_retry", 32'(retry_count), 0);
    check("hr_axis", 32'(axis_resetn), 0);
    check("hr_gt_all", 32'(gt_reset_all_out), 0);
    check("hr_rxdp", 32'(gt_reset_rx_datapath_out), 0);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
